uart_receiver: RTL and testbench

Serial-to-parallel UART receiver, 8N1, LSB first, for the ULX3S UART path. It is the receive counterpart to the transmit side. It samples the asynchronous `rx` pin, validates the start bit and checks the stop bit. Each accepted byte is presented as `data` with a single-cycle `data_ready` strobe; a frame whose stop bit is low raises `frame_err` instead.

---
 rtl/uart_receiver.sv | 121 ++++++++++++
 tb/tb_uart_receiver.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first. It samples rx at mid-bit after a 2-flop synchronizer.
// Good frames update data with a data_ready strobe; a low stop bit strobes frame_err instead.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_ready,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t      state;
  logic        rx_meta;
  logic        rx_s;
  logic [15:0] ccount;
  logic [2:0]  bidx;
  logic [7:0]  shreg;

  // rx is asynchronous; only rx_s may feed the FSM
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      ccount     <= 16'd0;
      bidx       <= 3'd0;
      shreg      <= 8'h00;
      data       <= 8'h00;
      data_ready <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          ccount <= 16'd0;
          if (!rx_s) begin
            state <= S_START;
            busy  <= 1'b1;
          end
        end

        S_START: begin
          if (ccount == HALF) begin
            ccount <= 16'd0;
            if (!rx_s) begin
              state <= S_DATA;
              bidx  <= 3'd0;
            end else begin
              // start bit did not survive to mid-bit: treat as a glitch
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            ccount <= ccount + 16'd1;
          end
        end

        S_DATA: begin
          if (ccount == LAST) begin
            ccount      <= 16'd0;
            shreg[bidx] <= rx_s;
            if (bidx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bidx <= bidx + 3'd1;
            end
          end else begin
            ccount <= ccount + 16'd1;
          end
        end

        S_STOP: begin
          if (ccount == LAST) begin
            // leave at mid-stop so a back-to-back start edge is caught in idle
            ccount <= 16'd0;
            state  <= S_IDLE;
            busy   <= 1'b0;
            if (rx_s) begin
              data       <= shreg;
              data_ready <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            ccount <= ccount + 16'd1;
          end
        end

        default: begin
          state  <= S_IDLE;
          ccount <= 16'd0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed table, corner sequences, and random frames.
// The bench compares DUT pulses against a frame-level model of when each pulse should occur.
module tb_uart_receiver;

  localparam int CPB      = 16;
  localparam int HALF     = (CPB - 1) / 2;
  localparam int PULSE_AT = 2 + HALF + 9 * CPB;  // cycles from T to the pulse
  localparam int LAT      = PULSE_AT + 2;        // pin edge to pulse, including the synchronizer
  localparam int BREAK_LEN = 540;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       data_ready;
  logic       frame_err;
  logic       busy;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx         (rx),
    .data       (data),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] t;
    logic        dr;
    logic        fe;
    logic [7:0]  d;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int   last_rise = -1;
  int   last_fall = -1;
  logic busy_q = 1'b0;

  always @(negedge clk) begin
    if (resetn && (data_ready || frame_err)) begin
      check("pulse_exclusive", 32'(data_ready & frame_err), 32'd0);
      obs_q.push_back({32'(cyc), data_ready, frame_err, data});
    end
    if (busy && !busy_q) last_rise = cyc;
    if (!busy && busy_q) last_fall = cyc;
    busy_q = busy;
  end

  logic [7:0] last_good = 8'h00;

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int edge_t);
    edge_t = cyc;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop, CPB);
    rx = 1'b1;
  endtask

  // Frame-level model: one pulse LAT cycles after the start edge.
  task automatic expect_frame(input int edge_t, input logic [7:0] b, input logic stop);
    exp_q.push_back({32'(edge_t + LAT), stop, !stop, stop ? b : last_good});
    if (stop) last_good = b;
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      $display("%s frame %0d: t=%0d dr=%0b fe=%0b data=%02h (want t=%0d dr=%0b fe=%0b data=%02h)",
               tag, i, obs_q[i].t, obs_q[i].dr, obs_q[i].fe, obs_q[i].d,
               exp_q[i].t, exp_q[i].dr, exp_q[i].fe, exp_q[i].d);
      check({tag, "_time"}, obs_q[i].t, exp_q[i].t);
      check({tag, "_kind"}, {30'd0, obs_q[i].dr, obs_q[i].fe}, {30'd0, exp_q[i].dr, exp_q[i].fe});
      check({tag, "_data"}, 32'(obs_q[i].d), 32'(exp_q[i].d));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         gap_bits;
    logic       exp_dr;
    logic       exp_fe;
    logic [7:0] exp_d;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int         e;
    int         g;
    int         gapc;
    logic [7:0] rb;
    logic       rs;

    tbl[0] = '{8'h55, 1'b0, 1, 1'b0, 1'b1, 8'hAB};  // framing error keeps 0xAB
    tbl[1] = '{8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00};
    tbl[2] = '{8'hFF, 1'b1, 1, 1'b1, 1'b0, 8'hFF};  // back-to-back with 0x00
    tbl[3] = '{8'h80, 1'b1, 0, 1'b1, 1'b0, 8'h80};
    tbl[4] = '{8'h01, 1'b0, 2, 1'b0, 1'b1, 8'h80};
    tbl[5] = '{8'h3C, 1'b1, 1, 1'b1, 1'b0, 8'h3C};

    // Reset
    rx = 1'b1;
    resetn = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("reset_data", 32'(data), 32'h00);
    check("reset_data_ready", 32'(data_ready), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    repeat (100) @(negedge clk);
    check("reset_quiet_busy", 32'(last_rise), 32'hFFFF_FFFF);
    compare_events("reset_quiet");

    // Single frame 0xAB
    send_frame(8'hAB, 1'b1, e);
    expect_frame(e, 8'hAB, 1'b1);
    hold(1'b1, 2 * CPB);
    check("single_busy_rise", 32'(last_rise), 32'(e + 3));
    check("single_busy_fall", 32'(last_fall), 32'(e + LAT));
    check("single_data", 32'(data), 32'hAB);
    compare_events("single");

    // Table: framing errors and back-to-back frames
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].b, tbl[i].stop, e);
      exp_q.push_back({32'(e + LAT), tbl[i].exp_dr, tbl[i].exp_fe, tbl[i].exp_d});
      if (tbl[i].gap_bits > 0) hold(1'b1, tbl[i].gap_bits * CPB);
    end
    hold(1'b1, 2 * CPB);
    compare_events("table");
    check("table_data", 32'(data), 32'h3C);
    last_good = 8'h3C;

    // Glitch: 3 low cycles
    g = cyc;
    hold(1'b0, 3);
    hold(1'b1, 3 * CPB);
    check("glitch_busy_rise", 32'(last_rise), 32'(g + 3));
    check("glitch_busy_fall", 32'(last_fall), 32'(g + 4 + HALF));
    check("glitch_data", 32'(data), 32'(last_good));
    compare_events("glitch");

    // Reset during data bit 4 of 0x3C
    rb = 8'h3C;
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(rb[i], CPB);
    hold(rb[4], CPB / 2);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_data", 32'(data), 32'h00);
    check("midreset_pulses", 32'({data_ready, frame_err}), 32'd0);
    last_good = 8'h00;
    hold(1'b1, 12 * CPB);
    compare_events("midreset");
    send_frame(8'h3C, 1'b1, e);
    expect_frame(e, 8'h3C, 1'b1);
    hold(1'b1, 2 * CPB);
    compare_events("after_reset");
    check("after_reset_data", 32'(data), 32'h3C);

    // Random frames with random gaps; a bad stop is always followed by an idle bit
    for (int k = 0; k < 20; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 7) != 0);
      send_frame(rb, rs, e);
      expect_frame(e, rb, rs);
      gapc = rs ? int'($urandom_range(0, 2 * CPB)) : int'($urandom_range(CPB, 3 * CPB));
      hold(1'b1, gapc);
    end
    hold(1'b1, 2 * CPB);
    compare_events("random");
    check("random_data", 32'(data), 32'(last_good));

    // Break: line held low gives one frame_err per frame time
    e = cyc;
    hold(1'b0, BREAK_LEN);
    for (int t = e + LAT; t < e + BREAK_LEN; t += PULSE_AT)
      exp_q.push_back({32'(t), 1'b0, 1'b1, last_good});
    rx = 1'b1;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    compare_events("break");
    last_good = 8'h00;
    repeat (4) @(negedge clk);
    check("break_reset_data", 32'(data), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
